// File: rtl/defines.sv
// ---------------------------------------------------------------------------
// defines.sv : memory geometry and arbiter state codes shared across the core
// ---------------------------------------------------------------------------
`default_nettype none
`ifndef MEM_ARBITER_DEFINES_SV
`define MEM_ARBITER_DEFINES_SV

`define WORD_SIZE        32
`define CACHE_LINE_SIZE  128

`define ARB_IDLE         3'd0
`define ARB_ISSUE_RD     3'd1
`define ARB_WAIT         3'd2
`define ARB_RESP         3'd3
`define ARB_WRITE        3'd4

`endif
`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : single-outstanding arbiter of iCache/dCache refills and dCache
//               writebacks onto one memory port.                   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`ifndef MEM_ARBITER_DEFINES_SV
`include "defines.sv"
`endif

module mem_arbiter #(
  parameter int WORD_SIZE = `WORD_SIZE,
  parameter int LINE_SIZE = `CACHE_LINE_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ic_req,
  input  logic [WORD_SIZE-1:0] ic_req_addr,
  input  logic                 dc_req,
  input  logic [WORD_SIZE-1:0] dc_req_addr,
  input  logic                 dc_wb,
  input  logic [WORD_SIZE-1:0] dc_wb_addr,
  input  logic [LINE_SIZE-1:0] dc_wb_data,
  output logic                 ic_res,
  output logic                 dc_res,
  output logic [WORD_SIZE-1:0] res_addr,
  output logic [LINE_SIZE-1:0] res_data,
  output logic                 dc_wb_done,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_req_addr,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_write_addr,
  output logic [LINE_SIZE-1:0] mem_write_data,
  input  logic                 mem_res,
  input  logic [WORD_SIZE-1:0] mem_res_addr,
  input  logic [LINE_SIZE-1:0] mem_res_data
);

  typedef enum logic [2:0] {
    IDLE     = `ARB_IDLE,
    ISSUE_RD = `ARB_ISSUE_RD,
    WAIT     = `ARB_WAIT,
    RESP     = `ARB_RESP,
    WRITE    = `ARB_WRITE
  } state_t;

  state_t               state_q, state_d;
  logic                 last_dc_q, last_dc_d;   // last read served went to dCache
  logic                 owner_dc_q, owner_dc_d;
  logic [WORD_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [WORD_SIZE-1:0] wb_addr_q, wb_addr_d;
  logic [LINE_SIZE-1:0] wb_data_q, wb_data_d;
  logic [WORD_SIZE-1:0] res_addr_q, res_addr_d;
  logic [LINE_SIZE-1:0] res_data_q, res_data_d;
  logic                 grant_dc;

  always_comb begin
    state_d    = state_q;
    last_dc_d  = last_dc_q;
    owner_dc_d = owner_dc_q;
    rd_addr_d  = rd_addr_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    res_addr_d = res_addr_q;
    res_data_d = res_data_q;
    // On contention the requester not served last time wins.
    grant_dc   = dc_req & ~(ic_req & last_dc_q);

    case (state_q)
      IDLE: begin
        if (dc_wb) begin
          wb_addr_d = dc_wb_addr;
          wb_data_d = dc_wb_data;
          state_d   = WRITE;
        end else if (ic_req | dc_req) begin
          owner_dc_d = grant_dc;
          rd_addr_d  = grant_dc ? dc_req_addr : ic_req_addr;
          state_d    = ISSUE_RD;
        end
      end
      ISSUE_RD: state_d = WAIT;
      WAIT: begin
        if (mem_res && (mem_res_addr == rd_addr_q)) begin
          res_addr_d = mem_res_addr;
          res_data_d = mem_res_data;
          state_d    = RESP;
        end
      end
      RESP: begin
        last_dc_d = owner_dc_q;
        state_d   = IDLE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_dc_q  <= 1'b0;
      owner_dc_q <= 1'b0;
      rd_addr_q  <= '0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      res_addr_q <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      last_dc_q  <= last_dc_d;
      owner_dc_q <= owner_dc_d;
      rd_addr_q  <= rd_addr_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      res_addr_q <= res_addr_d;
      res_data_q <= res_data_d;
    end
  end

  assign mem_req        = (state_q == ISSUE_RD);
  assign mem_req_addr   = rd_addr_q;
  assign mem_write      = (state_q == WRITE);
  assign dc_wb_done     = (state_q == WRITE);
  assign mem_write_addr = wb_addr_q;
  assign mem_write_data = wb_data_q;
  assign ic_res         = (state_q == RESP) & ~owner_dc_q;
  assign dc_res         = (state_q == RESP) &  owner_dc_q;
  assign res_addr       = res_addr_q;
  assign res_data       = res_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed scenarios plus randomized traffic checked against
//                  a transaction-level model of the arbiter.       rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;
  localparam int W = 32;
  localparam int L = 128;

  logic         clk, rst;
  logic         ic_req, dc_req, dc_wb, mem_res;
  logic [W-1:0] ic_req_addr, dc_req_addr, dc_wb_addr, mem_res_addr;
  logic [L-1:0] dc_wb_data, mem_res_data;
  logic         ic_res, dc_res, dc_wb_done, mem_req, mem_write;
  logic [W-1:0] res_addr, mem_req_addr, mem_write_addr;
  logic [L-1:0] res_data, mem_write_data;

  int checks = 0;
  int passed = 0;

  mem_arbiter #(.WORD_SIZE(W), .LINE_SIZE(L)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_req_addr(ic_req_addr),
    .dc_req(dc_req), .dc_req_addr(dc_req_addr),
    .dc_wb(dc_wb), .dc_wb_addr(dc_wb_addr), .dc_wb_data(dc_wb_data),
    .ic_res(ic_res), .dc_res(dc_res), .res_addr(res_addr), .res_data(res_data),
    .dc_wb_done(dc_wb_done),
    .mem_req(mem_req), .mem_req_addr(mem_req_addr),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_res(mem_res), .mem_res_addr(mem_res_addr), .mem_res_data(mem_res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level model: the arbiter can sample requests from edge
  // can_sample on; a granted read completes on the first matching response
  // sampled two or more edges after the grant.
  int           edge_n = 0;
  int           can_sample = 0;
  int           wait_edge = 0;
  bit           m_wait = 0, m_owner_dc = 0, m_last_dc = 0;
  logic [W-1:0] m_addr = '0;
  logic         e_mem_req, e_mem_write, e_ic_res, e_dc_res;
  logic [W-1:0] e_req_addr, e_wr_addr, e_res_addr;
  logic [L-1:0] e_wr_data, e_res_data;
  int           n_req = 0, n_ic = 0, n_dc = 0, n_wr = 0;

  always @(posedge clk) begin
    edge_n++;
    e_mem_req = 0; e_mem_write = 0; e_ic_res = 0; e_dc_res = 0;
    if (!rst) begin
      m_wait = 0; can_sample = 0; m_last_dc = 0;
      e_res_addr = '0; e_res_data = '0;
    end else if (m_wait) begin
      if (edge_n >= wait_edge && mem_res && mem_res_addr == m_addr) begin
        e_ic_res = !m_owner_dc; e_dc_res = m_owner_dc;
        e_res_addr = mem_res_addr; e_res_data = mem_res_data;
        m_last_dc = m_owner_dc; m_wait = 0; can_sample = edge_n + 2;
      end
    end else if (edge_n >= can_sample) begin
      if (dc_wb) begin
        e_mem_write = 1; e_wr_addr = dc_wb_addr; e_wr_data = dc_wb_data;
        can_sample = edge_n + 2;
      end else if (ic_req || dc_req) begin
        m_owner_dc = dc_req && !(ic_req && m_last_dc);
        m_addr = m_owner_dc ? dc_req_addr : ic_req_addr;
        e_mem_req = 1; e_req_addr = m_addr;
        m_wait = 1; wait_edge = edge_n + 2;
      end
    end
    #1;
    chk("mem_req", mem_req, e_mem_req);
    chk("mem_write", mem_write, e_mem_write);
    chk("dc_wb_done", dc_wb_done, e_mem_write);
    chk("ic_res", ic_res, e_ic_res);
    chk("dc_res", dc_res, e_dc_res);
    chk("res_addr", res_addr, e_res_addr);
    chk("res_data", res_data, e_res_data);
    if (e_mem_req) chk("mem_req_addr", mem_req_addr, e_req_addr);
    if (e_mem_write) begin
      chk("mem_write_addr", mem_write_addr, e_wr_addr);
      chk("mem_write_data", mem_write_data, e_wr_data);
    end
    if (mem_req) n_req++;
    if (ic_res) n_ic++;
    if (dc_res) n_dc++;
    if (mem_write) n_wr++;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_inputs();
    ic_req = 0; dc_req = 0; dc_wb = 0; mem_res = 0;
    ic_req_addr = '0; dc_req_addr = '0; dc_wb_addr = '0; mem_res_addr = '0;
    dc_wb_data = '0; mem_res_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    cyc(2);
    rst = 1;
  endtask

  // which: 0 ic_res, 1 dc_res, 2 dc_wb_done, 3 mem_req
  task automatic wait_for(input int which, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc(1);
      case (which)
        0: ok = ic_res;
        1: ok = dc_res;
        2: ok = dc_wb_done;
        default: ok = mem_req;
      endcase
    end
    if (!ok) begin
      checks++;
      $display("FAIL timeout: strobe %0d not seen within %0d cycles", which, budget);
    end
  endtask

  task automatic serve_read(input int lat, output logic [W-1:0] a, output bit was_dc);
    bit ok;
    a = '0; was_dc = 0;
    wait_for(3, 12, ok);
    if (ok) begin
      a = mem_req_addr;
      cyc(lat);
      mem_res = 1; mem_res_addr = a; mem_res_data = {(L/W){a}};
      cyc(1);
      mem_res = 0;
      was_dc = dc_res;
      chk("single_res_pulse", ic_res ^ dc_res, 1'b1);
    end
  endtask

  logic [W-1:0] a;
  bit           was_dc, ok;
  int           s_req, s_ic, s_dc, s_wr, resp_cnt;
  bit           ic_drop, dc_drop, wb_drop;
  logic [W-1:0] pend_addr;

  initial begin
    clear_inputs();
    rst = 0;
    cyc(3);
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_res_data", res_data, '0);
    rst = 1;

    // single iCache refill, response five cycles after the read command
    s_req = n_req; s_ic = n_ic; s_dc = n_dc;
    ic_req = 1; ic_req_addr = 32'h1000;
    wait_for(3, 10, ok);
    chk("t1_req_addr", mem_req_addr, 32'h1000);
    cyc(5);
    mem_res = 1; mem_res_addr = 32'h1000; mem_res_data = {(L/8){8'hA5}};
    cyc(1);
    mem_res = 0;
    chk("t1_ic_res", ic_res, 1'b1);
    chk("t1_dc_res", dc_res, 1'b0);
    chk("t1_res_addr", res_addr, 32'h1000);
    chk("t1_res_data", res_data, {(L/8){8'hA5}});
    cyc(1); ic_req = 0;
    cyc(3);
    chk("t1_req_count", n_req - s_req, 1);
    chk("t1_ic_count", n_ic - s_ic, 1);
    chk("t1_dc_count", n_dc - s_dc, 0);

    // simultaneous refills: dCache first after reset, then iCache
    do_reset();
    s_req = n_req;
    ic_req = 1; ic_req_addr = 32'h1000; dc_req = 1; dc_req_addr = 32'h2000;
    serve_read(2, a, was_dc);
    chk("t2_first_addr", a, 32'h2000);
    chk("t2_first_dc", was_dc, 1'b1);
    cyc(1); dc_req = 0;
    serve_read(3, a, was_dc);
    chk("t2_second_addr", a, 32'h1000);
    chk("t2_second_dc", was_dc, 1'b0);
    cyc(1); ic_req = 0;
    cyc(4);
    chk("t2_req_count", n_req - s_req, 2);

    // writeback outranks a concurrent refill
    do_reset();
    s_req = n_req; s_wr = n_wr;
    dc_wb = 1; dc_wb_addr = 32'h3000; dc_wb_data = {$urandom, $urandom, $urandom, $urandom};
    ic_req = 1; ic_req_addr = 32'h1000;
    wait_for(2, 5, ok);
    chk("t3_write_addr", mem_write_addr, 32'h3000);
    chk("t3_no_read_yet", n_req - s_req, 0);
    cyc(1); dc_wb = 0;
    serve_read(1, a, was_dc);
    chk("t3_read_addr", a, 32'h1000);
    cyc(1); ic_req = 0;
    chk("t3_write_count", n_wr - s_wr, 1);

    // a response for a foreign address is ignored in WAIT
    do_reset();
    s_ic = n_ic;
    ic_req = 1; ic_req_addr = 32'h1000;
    wait_for(3, 10, ok);
    cyc(2);
    mem_res = 1; mem_res_addr = 32'h4000; mem_res_data = {(L/W){32'hDEAD_BEEF}};
    cyc(1); mem_res = 0;
    chk("t4_foreign_ignored", ic_res, 1'b0);
    cyc(2);
    mem_res = 1; mem_res_addr = 32'h1000; mem_res_data = {(L/W){32'h1234_5678}};
    cyc(1); mem_res = 0;
    chk("t4_ic_res", ic_res, 1'b1);
    chk("t4_res_data", res_data, {(L/W){32'h1234_5678}});
    cyc(1); ic_req = 0;
    chk("t4_ic_count", n_ic - s_ic, 1);

    // asynchronous reset while waiting abandons the read
    do_reset();
    ic_req = 1; ic_req_addr = 32'h1000;
    wait_for(3, 10, ok);
    cyc(2);
    #3 rst = 0; ic_req = 0;
    #1;
    chk("t5_rst_mem_req", mem_req, 1'b0);
    chk("t5_rst_strobes", {mem_write, ic_res, dc_res, dc_wb_done}, 4'b0);
    chk("t5_rst_res_addr", res_addr, '0);
    cyc(2);
    rst = 1;
    s_req = n_req; s_ic = n_ic; s_dc = n_dc;
    cyc(1);
    mem_res = 1; mem_res_addr = 32'h1000; mem_res_data = {(L/W){32'hCAFE_F00D}};
    cyc(1); mem_res = 0;
    cyc(3);
    chk("t5_no_res", (n_ic - s_ic) + (n_dc - s_dc), 0);
    chk("t5_no_req", n_req - s_req, 0);

    // request held through the pulse cycle yields a single grant
    do_reset();
    s_req = n_req;
    ic_req = 1; ic_req_addr = 32'h1000;
    serve_read(4, a, was_dc);
    cyc(1); ic_req = 0;
    cyc(5);
    chk("t6_single_grant", n_req - s_req, 1);

    // randomized traffic from three requesters against a variable-latency memory
    do_reset();
    resp_cnt = 0; ic_drop = 0; dc_drop = 0; wb_drop = 0; pend_addr = '0;
    for (int it = 0; it < 4000; it++) begin
      cyc(1);
      mem_res = 0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_res = 1; mem_res_addr = pend_addr;
          mem_res_data = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if ($urandom_range(0, 9) == 0) begin
        mem_res = 1; mem_res_addr = 32'h4000 + ($urandom_range(0, 3) << 8);
        mem_res_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (mem_req) begin
        pend_addr = mem_req_addr;
        resp_cnt = $urandom_range(1, 6);
      end
      if (ic_drop) begin ic_req = 0; ic_drop = 0; end
      else if (ic_req && ic_res) ic_drop = 1;
      else if (!ic_req && $urandom_range(0, 3) == 0) begin
        ic_req = 1; ic_req_addr = 32'h1000 + ($urandom_range(0, 3) << 8);
      end
      if (dc_drop) begin dc_req = 0; dc_drop = 0; end
      else if (dc_req && dc_res) dc_drop = 1;
      else if (!dc_req && $urandom_range(0, 3) == 0) begin
        dc_req = 1; dc_req_addr = 32'h2000 + ($urandom_range(0, 3) << 8);
      end
      if (wb_drop) begin dc_wb = 0; wb_drop = 0; end
      else if (dc_wb && dc_wb_done) wb_drop = 1;
      else if (!dc_wb && $urandom_range(0, 7) == 0) begin
        dc_wb = 1; dc_wb_addr = 32'h3000 + ($urandom_range(0, 3) << 8);
        dc_wb_data = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    clear_inputs();
    cyc(10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default `WORD_SIZE, address/word width.
REQ-002 Parameter LINE_SIZE, default `CACHE_LINE_SIZE, refill/writeback line width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 ic_req / ic_req_addr  input  1 / WORD_SIZE  iCache refill request, held high until ic_res.
REQ-006 dc_req / dc_req_addr  input  1 / WORD_SIZE  dCache refill request, held high until dc_res.
REQ-007 dc_wb / dc_wb_addr / dc_wb_data  input  1 / WORD_SIZE / LINE_SIZE  dCache writeback, held high until dc_wb_done.
REQ-008 ic_res / dc_res  output  1 each  one-cycle refill-complete pulse to owner.
REQ-009 res_addr / res_data  output  WORD_SIZE / LINE_SIZE  registered refill address/line, shared by both requesters.
REQ-010 dc_wb_done  output  1  one-cycle writeback-accepted pulse.
REQ-011 mem_req / mem_req_addr  output  1 / WORD_SIZE  memory read command, one-cycle pulse.
REQ-012 mem_write / mem_write_addr / mem_write_data  output  1 / WORD_SIZE / LINE_SIZE  memory write command, one-cycle pulse.
REQ-013 mem_res / mem_res_addr / mem_res_data  input  1 / WORD_SIZE / LINE_SIZE  memory read response, one-cycle pulse, arbitrary latency.

Function
REQ-014 States IDLE, ISSUE_RD, WAIT, RESP, WRITE; at most one memory transaction outstanding.
REQ-015 IDLE: if dc_wb high -> WRITE; else if any read request -> grant per REQ-016, latch owner and address, -> ISSUE_RD; else stay.
REQ-016 Read grant: only one of ic_req/dc_req high -> that one; both high -> requester opposite to last-served (rr bit), rr bit initialised to favour dCache.
REQ-017 ISSUE_RD: mem_req=1 with latched address for exactly one cycle, -> WAIT.
REQ-018 WAIT: on mem_res with mem_res_addr equal to latched address -> capture data, -> RESP; non-matching mem_res ignored, stay in WAIT.
REQ-019 RESP: owner's ic_res or dc_res =1 for exactly one cycle with res_addr/res_data valid; rr bit updated; -> IDLE.
REQ-020 WRITE: mem_write=1 and dc_wb_done=1 for exactly one cycle with latched writeback address/data; -> IDLE.
REQ-021 RESP and WRITE each return to IDLE, so a held request cannot be granted twice (requester drops it the cycle after its pulse).
REQ-022 Latency: request sampled in IDLE cycle N -> mem_req cycle N+1; mem_res cycle M -> ic_res/dc_res cycle M+1; next grant sampled no earlier than M+2.
REQ-023 Requests arriving outside IDLE are not lost; they are serviced once IDLE is reached, provided the requester still holds them.
REQ-024 mem_req and mem_write never high in the same cycle; ic_res and dc_res never high in the same cycle.
REQ-025 Address/data outputs to memory are don't-care when corresponding strobe is low; they hold latched values.

Reset
REQ-026 On rst=0, immediately: state=IDLE, rr bit=dCache-first, all strobes (mem_req, mem_write, ic_res, dc_res, dc_wb_done)=0, res_addr/res_data/latched registers=0.
REQ-027 Reset mid-transaction abandons it; a later mem_res for the abandoned address is ignored in IDLE.
REQ-028 mem_res received in any state other than WAIT is ignored.

Structure
REQ-029 State encoding and the default memory parameters live in defines.sv as `define constants shared with cache and stage modules.
REQ-030 Single flat module; no sub-module (2-way rr grant is inline logic).

Verification
REQ-031 ic_req=1, addr=0x1000, mem_res at +5 cycles with data 0xA5.. -> mem_req pulse once at 0x1000, ic_res one cycle after mem_res, res_data=0xA5.., no dc_res.
REQ-032 ic_req and dc_req both high same cycle (0x1000/0x2000), held -> dCache served first, then iCache; exactly two mem_req pulses, alternating owners.
REQ-033 dc_wb (0x3000) and ic_req together -> mem_write at 0x3000 with dc_wb_done first, then mem_req 0x1000.
REQ-034 In WAIT for 0x1000, inject mem_res at 0x4000 -> ignored; later mem_res at 0x1000 -> completes normally.
REQ-035 rst=0 asynchronously during WAIT, release, then mem_res 0x1000 -> no ic_res/dc_res; all strobes 0 during reset.
REQ-036 ic_req held through RESP cycle then dropped -> only one mem_req issued (no double grant).
